// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Initiator side of a 64-bit combinational ALU interface. ALU commands
// {op, a, b} are held in a small FIFO. The head entry drives the ALU, and
// one command issues per cycle. Each ALU result/Zero pair is registered into
// a single response slot that uses a valid/ready handshake. This lets
// multi-cycle datapath or test logic drive the ALU with backpressure.
//
// Supported aluop encodings are 0000 AND, 0001 OR, 0010 ADD, 0110 SUB and
// 1100 NOR. Any other encoding still issues and pops. It returns rsp_err=1
// with rsp_data/rsp_zero forced to zero, and the ALU outputs are ignored.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept (registered count < DEPTH)
//   cmd_op     in   4-bit aluop
//   cmd_a      in   operand a
//   cmd_b      in   operand b
//   alu_a      out  ALU operand a (FIFO head, zero when empty)
//   alu_b      out  ALU operand b (FIFO head, zero when empty)
//   alu_op     out  ALU aluop     (FIFO head, zero when empty)
//   alu_out    in   ALU result
//   alu_zero   in   ALU Zero flag
//   rsp_valid  out  response slot full
//   rsp_ready  in   consumer takes response
//   rsp_data   out  registered result
//   rsp_zero   out  registered Zero flag
//   rsp_err    out  command carried an unsupported aluop
//   count      out  FIFO occupancy, 0..DEPTH
//
// Optional feature (macro ALU_ISSUE_PERF_EN)
//   perf_issued out  32-bit count of issued commands
//   perf_zero   out  32-bit count of legal issues that returned alu_zero=1
//   Both counters wrap at 2^32 and are cleared by reset. When the macro is
//   undefined, these ports and counters do not exist.
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  count
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_zero
`endif
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_NOR = 4'b1100
  } alu_op_e;

  // FIFO storage and bookkeeping
  logic [3:0]        r_op_mem [DEPTH];
  logic [DATA_W-1:0] r_a_mem  [DEPTH];
  logic [DATA_W-1:0] r_b_mem  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Response slot
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;

  logic              w_empty;
  logic              w_push;
  logic              w_issue;
  logic [3:0]        w_head_op;
  logic              w_head_legal;

  assign w_empty   = (r_count == '0);
  // Ready looks only at the registered count. A pop in the same cycle does
  // not make room for a push into a full FIFO.
  assign cmd_ready = (r_count < CNT_W'(DEPTH));
  assign w_push    = cmd_valid & cmd_ready;
  assign w_issue   = !w_empty & (!r_rsp_valid | rsp_ready);
  assign w_head_op = r_op_mem[r_rd_ptr];

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_head_legal = 1'b0;
    case (w_head_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: w_head_legal = 1'b1;
      default:                               w_head_legal = 1'b0;
    endcase
  end

  // The head drives the ALU directly. A push into an empty FIFO first
  // appears here after the edge that accepts it, so there is no bypass.
  assign alu_a  = w_empty ? '0   : r_a_mem[r_rd_ptr];
  assign alu_b  = w_empty ? '0   : r_b_mem[r_rd_ptr];
  assign alu_op = w_empty ? 4'b0 : w_head_op;

  // NOTE: the payload memory has no reset. The count and pointers decide
  // which entries are meaningful, so stale contents are never observed, and
  // omitting the reset keeps the array as plain storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr] <= cmd_op;
      r_a_mem[r_wr_ptr]  <= cmd_a;
      r_b_mem[r_wr_ptr]  <= cmd_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The response slot loads on issue. It clears when the consumer takes the
  // response and nothing is waiting, and otherwise holds stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_issue) begin
      r_rsp_valid <= 1'b1;
      if (w_head_legal) begin
        r_rsp_data <= alu_out;
        r_rsp_zero <= alu_zero;
        r_rsp_err  <= 1'b0;
      end else begin
        r_rsp_data <= '0;
        r_rsp_zero <= 1'b0;
        r_rsp_err  <= 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;
  assign count     = r_count;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_zero   <= '0;
    end else if (w_issue) begin
      r_perf_issued <= r_perf_issued + 32'd1;
      if (w_head_legal && alu_zero) r_perf_zero <= r_perf_zero + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_zero   = r_perf_zero;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
//
// This bench checks alu_issue_unit against a queue-based reference model.
// The model keeps a queue of pending commands plus one response slot, and
// computes every ALU result from the aluop definitions. A behavioural ALU
// sits on the alu_* wires. For unsupported ops, that ALU returns a nonzero
// pattern with Zero=1, so any result leaking through on an illegal op
// shows up as an error.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op    = 4'b0;
  logic [DATA_W-1:0] cmd_a     = '0;
  logic [DATA_W-1:0] cmd_b     = '0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic [CNT_W-1:0]  count;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_zero;
`endif

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .count     (count)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_zero   (perf_zero)
`endif
  );

  // Behavioural ALU attached to the issue unit
  always_comb begin
    alu_out  = 64'hDEAD_BEEF_0BAD_F00D;
    alu_zero = 1'b1;
    case (alu_op)
      OP_AND: begin alu_out = alu_a & alu_b;    alu_zero = (alu_out == '0); end
      OP_OR:  begin alu_out = alu_a | alu_b;    alu_zero = (alu_out == '0); end
      OP_ADD: begin alu_out = alu_a + alu_b;    alu_zero = (alu_out == '0); end
      OP_SUB: begin alu_out = alu_a - alu_b;    alu_zero = (alu_out == '0); end
      OP_NOR: begin alu_out = ~(alu_a | alu_b); alu_zero = (alu_out == '0); end
      default: ;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              err;
  } rsp_t;

  cmd_t              m_q[$];
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;
  logic              m_zero  = 1'b0;
  logic              m_err   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic rsp_t golden(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    rsp_t r;
    r.err  = 1'b0;
    r.data = '0;
    case (op)
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_ADD:  r.data = a + b;
      OP_SUB:  r.data = a - b;
      OP_NOR:  r.data = ~(a | b);
      default: r.err = 1'b1;
    endcase
    r.zero = !r.err && (r.data == '0);
    return r;
  endfunction

  function automatic logic [3:0] rand_legal_op();
    case ($urandom_range(0, 4))
      0:       return OP_AND;
      1:       return OP_OR;
      2:       return OP_ADD;
      3:       return OP_SUB;
      default: return OP_NOR;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Drives one cycle of inputs and advances the model across the same edge.
  // It returns #1 after the edge, when outputs are stable.
  task automatic step(input logic v, input logic [3:0] op, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic rdy);
    cmd_t c;
    rsp_t r;
    bit   do_push;
    bit   do_issue;
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = rdy;
    do_push   = v && (m_q.size() < DEPTH);
    do_issue  = (m_q.size() > 0) && (!m_valid || rdy);
    if (do_issue) begin
      c       = m_q.pop_front();
      r       = golden(c.op, c.a, c.b);
      m_valid = 1'b1;
      m_data  = r.data;
      m_zero  = r.zero;
      m_err   = r.err;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (do_push) begin
      c.op = op;
      c.a  = a;
      c.b  = b;
      m_q.push_back(c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 4'b0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_zero  = 1'b0;
    m_err   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_rsp: valid=%b data=%h zero=%b err=%b, want all zero",
               rsp_valid, rsp_data, rsp_zero, rsp_err);
    end
    n_checks++;
    if (count !== 3'd0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_fifo: count=%0d ready=%b, want 0/1", count, cmd_ready);
    end
    n_checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_alu_drive: a=%h b=%h op=%b, want zeros", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_basic();
    step(1'b1, OP_ADD, 64'd5, 64'd7, 1'b1);
    n_checks++;
    if (rsp_valid !== 1'b0 || count !== 3'd1 || alu_op !== OP_ADD || alu_a !== 64'd5) begin
      n_errors++;
      $display("FAIL add_accept: valid=%b count=%0d op=%b a=%0d, want 0/1/0010/5",
               rsp_valid, count, alu_op, alu_a);
    end
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL add_rsp: valid=%b data=%0d zero=%b err=%b, want 1/12/0/0",
               rsp_valid, rsp_data, rsp_zero, rsp_err);
    end
    step(1'b1, OP_SUB, 64'd9, 64'd9, 1'b1);
    step(1'b1, OP_NOR, 64'd0, 64'd0, 1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_zero !== 1'b1 || count !== 3'd1) begin
      n_errors++;
      $display("FAIL sub_rsp: valid=%b data=%h zero=%b count=%0d, want 1/0/1/1",
               rsp_valid, rsp_data, rsp_zero, count);
    end
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL nor_rsp: valid=%b data=%h zero=%b, want 1/ffffffffffffffff/0",
               rsp_valid, rsp_data, rsp_zero);
    end
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL consume_clear: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_t exp[5];
    for (int i = 0; i < 5; i++) begin
      logic [3:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      op     = rand_legal_op();
      a      = rand64();
      b      = rand64();
      exp[i] = golden(op, a, b);
      step(1'b1, op, a, b, 1'b0);
    end
    n_checks++;
    if (count !== 3'd4 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: count=%0d ready=%b valid=%b, want 4/0/1", count, cmd_ready, rsp_valid);
    end
    // Offer a sixth command while full: it must be refused.
    step(1'b1, OP_ADD, 64'd1, 64'd1, 1'b0);
    n_checks++;
    if (count !== 3'd4 || rsp_data !== exp[0].data) begin
      n_errors++;
      $display("FAIL bp_hold: count=%0d data=%h, want 4/%h", count, rsp_data, exp[0].data);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i].data || rsp_zero !== exp[i].zero) begin
        n_errors++;
        $display("FAIL bp_drain[%0d]: valid=%b data=%h zero=%b, want 1/%h/%b",
                 i, rsp_valid, rsp_data, rsp_zero, exp[i].data, exp[i].zero);
      end
      idle(1'b1);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++;
      $display("FAIL bp_empty: valid=%b count=%0d, want 0/0", rsp_valid, count);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 4'b0111, rand64(), rand64(), 1'b1);
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_rsp: valid=%b err=%b data=%h zero=%b, want 1/1/0/0",
               rsp_valid, rsp_err, rsp_data, rsp_zero);
    end
    step(1'b1, OP_ADD, 64'd3, 64'd4, 1'b1);
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 64'd7 || rsp_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL after_illegal: valid=%b err=%b data=%0d zero=%b, want 1/0/7/0",
               rsp_valid, rsp_err, rsp_data, rsp_zero);
    end
    idle(1'b1);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) step(1'b1, OP_ADD, rand64(), rand64(), 1'b0);
    n_checks++;
    if (count !== 3'd3 || rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset: count=%0d valid=%b, want 3/1", count, rsp_valid);
    end
    do_reset();
    n_checks++;
    if (count !== 3'd0 || rsp_valid !== 1'b0 || alu_op !== 4'b0 || rsp_data !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: count=%0d valid=%b op=%b data=%h, want 0/0/0/0",
               count, rsp_valid, alu_op, rsp_data);
    end
    step(1'b1, OP_OR, 64'hF0, 64'h0F, 1'b1);
    idle(1'b1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'hFF || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_cmd: valid=%b data=%h err=%b, want 1/ff/0", rsp_valid, rsp_data, rsp_err);
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [3:0]        exp_op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : rand_legal_op();
      a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : rand64();
      b  = ($urandom_range(0, 4) == 0) ? a : rand64();
      step(1'($urandom_range(0, 1)), op, a, b, 1'($urandom_range(0, 2) != 0));
      n_checks++;
      if (rsp_valid !== m_valid ||
          (m_valid && (rsp_data !== m_data || rsp_zero !== m_zero || rsp_err !== m_err))) begin
        n_errors++;
        $display("FAIL rand_rsp@%0d: valid=%b data=%h zero=%b err=%b, want %b/%h/%b/%b",
                 cyc, rsp_valid, rsp_data, rsp_zero, rsp_err, m_valid, m_data, m_zero, m_err);
      end
      exp_op = (m_q.size() > 0) ? m_q[0].op : 4'b0;
      n_checks++;
      if (count !== CNT_W'(m_q.size()) || cmd_ready !== (m_q.size() < DEPTH) || alu_op !== exp_op) begin
        n_errors++;
        $display("FAIL rand_fifo@%0d: count=%0d ready=%b op=%b, want %0d/%b/%b",
                 cyc, count, cmd_ready, alu_op, m_q.size(), (m_q.size() < DEPTH), exp_op);
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    n_checks++;
    if (count !== 3'd0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rand_drain: count=%0d valid=%b, want 0/0", count, rsp_valid);
    end
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    do_reset();
    step(1'b1, OP_ADD, 64'd5, 64'd7, 1'b1);
    step(1'b1, OP_SUB, 64'd9, 64'd9, 1'b1);
    step(1'b1, OP_NOR, 64'd0, 64'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    n_checks++;
    if (perf_issued !== 32'd3 || perf_zero !== 32'd1) begin
      n_errors++;
      $display("FAIL perf: issued=%0d zero=%0d, want 3/1", perf_issued, perf_zero);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_reset_midstream();
    test_random();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
